// File: rtl/platform_pkg.sv
// Shared definitions for the scrolling platform field: screen geometry
// defaults, LFSR constants, platform record and controller states.
package platform_pkg;

   localparam int COORD_W_DEF  = 10;
   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;
   localparam int HALF_W_DEF   = 4;

   // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
   localparam logic [15:0] LFSR_POLY     = 16'hB400;
   // An all-zero LFSR would lock up, so a zero seed is swapped for this
   localparam logic [15:0] LFSR_FALLBACK = 16'hACE1;

   typedef struct packed {
      logic [COORD_W_DEF-1:0] x;
      logic [COORD_W_DEF-1:0] y;
   } plat_t;

   typedef enum logic [1:0] {
      RESET_HOLD,
      INIT,
      IDLE,
      UPDATE
   } state_t;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
   endfunction

endpackage

// File: rtl/platform_field_lfsr.sv
// Free-running 16-bit Galois LFSR used to place platforms horizontally.
module plat_lfsr
   import platform_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   // Load the seed while in reset, otherwise advance one step per clock
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) value <= (seed == 16'd0) ? LFSR_FALLBACK : seed;
      else       value <= lfsr_step(value);
   end

endmodule

// File: rtl/platform_field.sv
// Platform field: holds N_PLAT platform centres, lays them out after reset,
// scrolls them down once per requested frame (respawning at the top with a
// fresh random X when they fall off), and reports per-pixel box hits.
module platform_field
   import platform_pkg::*;
#(
   parameter  int N_PLAT   = 16,
   parameter  int COORD_W  = COORD_W_DEF,
   parameter  int SCREEN_W = SCREEN_W_DEF,
   parameter  int SCREEN_H = SCREEN_H_DEF,
   parameter  int HALF_W   = HALF_W_DEF,
   localparam int IDX_W    = $clog2(N_PLAT)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic [COORD_W-1:0] scroll_amt,
   input  logic [15:0]        seed,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   output logic               platform_on,
   output logic [IDX_W-1:0]   hit_index,
   output logic               busy,
   output logic               overrun
);

   // The single-subtract X fold only covers the whole LFSR range when the
   // usable span is at least half the coordinate space.
   if (SCREEN_W - 2*HALF_W < (1 << (COORD_W-1))) begin : g_bad_geom
      $error("platform_field: SCREEN_W-2*HALF_W must be >= 2**(COORD_W-1)");
   end
   if (N_PLAT < 2 || N_PLAT > 64) begin : g_bad_count
      $error("platform_field: N_PLAT must be in 2..64");
   end
   if (COORD_W != COORD_W_DEF) begin : g_bad_coord
      $error("platform_field: COORD_W must match the plat_t record width");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PLAT-1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [COORD_W-1:0] scroll_q;
   plat_t              plat [N_PLAT];
   logic [15:0]        lfsr_value;
   logic               lfsr_unused;

   logic [COORD_W-1:0] x_new;
   logic [COORD_W-1:0] y_init;
   logic [COORD_W:0]   y_sum;
   logic               y_wrap;
   logic [COORD_W-1:0] y_upd;

   logic               hit_any_p0;
   logic [IDX_W-1:0]   hit_idx_p0;

   plat_lfsr u_lfsr (
      .Clk   (Clk),
      .Reset (Reset),
      .seed  (seed),
      .value (lfsr_value)
   );

   // Only the low coordinate bits feed the X mapping
   assign lfsr_unused = ^lfsr_value[15:COORD_W];

   // Fold an LFSR sample into [HALF_W, SCREEN_W-1-HALF_W]
   function automatic logic [COORD_W-1:0] map_x(input logic [COORD_W-1:0] r_in);
      logic [COORD_W-1:0] r;
      r = r_in;
      if (r > COORD_W'(SCREEN_W-1-2*HALF_W)) r = r - COORD_W'(SCREEN_W-2*HALF_W);
      return r + COORD_W'(HALF_W);
   endfunction

   // Signed box test so a centre near 0 never wraps its box around the screen
   function automatic logic in_box(input plat_t p,
                                   input logic [COORD_W-1:0] px_in,
                                   input logic [COORD_W-1:0] py_in);
      logic signed [COORD_W:0] px, py, cx, cy, h;
      px = $signed({1'b0, px_in});
      py = $signed({1'b0, py_in});
      cx = $signed({1'b0, p.x});
      cy = $signed({1'b0, p.y});
      h  = (COORD_W+1)'(HALF_W);
      return (px >= cx - h) && (px <= cx + h) && (py >= cy - h) && (py <= cy + h);
   endfunction

   // Next-entry values for the slot currently addressed by idx
   always_comb begin
      x_new  = map_x(lfsr_value[COORD_W-1:0]);
      y_init = COORD_W'(int'(idx) * (SCREEN_H / N_PLAT));
      y_sum  = {1'b0, plat[idx].y} + {1'b0, scroll_q};
      y_wrap = (y_sum >= (COORD_W+1)'(SCREEN_H));
      y_upd  = y_wrap ? COORD_W'(y_sum - (COORD_W+1)'(SCREEN_H)) : y_sum[COORD_W-1:0];
   end

   // Controller: reset hold, one-entry-per-cycle init and update passes
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= RESET_HOLD;
         idx      <= '0;
         scroll_q <= '0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
         for (int i = 0; i < N_PLAT; i++) plat[i] <= '0;
      end else begin
         if (frame_tick && busy) overrun <= 1'b1;
         case (state)
            RESET_HOLD: begin
               state <= INIT;
               idx   <= '0;
               busy  <= 1'b1;
            end
            INIT: begin
               plat[idx].x <= x_new;
               plat[idx].y <= y_init;
               if (idx == LAST_IDX) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  idx   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            IDLE: begin
               if (frame_tick) begin
                  state    <= UPDATE;
                  busy     <= 1'b1;
                  scroll_q <= scroll_amt;
                  idx      <= '0;
               end
            end
            UPDATE: begin
               plat[idx].y <= y_upd;
               if (y_wrap) plat[idx].x <= x_new;
               if (idx == LAST_IDX) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  idx   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= RESET_HOLD;
         endcase
      end
   end

   // Stage p0: scan all boxes, lowest index wins
   always_comb begin
      hit_any_p0 = 1'b0;
      hit_idx_p0 = '0;
      for (int i = N_PLAT-1; i >= 0; i--) begin
         if (in_box(plat[i], DrawX, DrawY)) begin
            hit_any_p0 = 1'b1;
            hit_idx_p0 = IDX_W'(i);
         end
      end
   end

   // Stage p1: register the pixel result one cycle after DrawX/DrawY
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         platform_on <= 1'b0;
         hit_index   <= '0;
      end else begin
         platform_on <= hit_any_p0;
         hit_index   <= hit_idx_p0;
      end
   end

endmodule

// File: doc/platform_field.md
PLATFORM_FIELD -- requirements
Module: platform_field

Interface
REQ-001 N_PLAT, 16, number of platforms held (2..64).
REQ-002 COORD_W, 10, width of every X/Y coordinate.
REQ-003 SCREEN_W, 640, visible width in pixels.
REQ-004 SCREEN_H, 480, visible height in pixels.
REQ-005 HALF_W, 4, platform half-size in pixels; the box covers centre +/- HALF_W.
REQ-006 Clk  in  1  system clock; all state changes on the rising edge.
REQ-007 Reset  in  1  reset, asynchronous, active-high.
REQ-008 frame_tick  in  1  one-Clk pulse per frame that requests an update pass.
REQ-009 scroll_amt  in  COORD_W  downward scroll applied this pass; legal range 0..SCREEN_H-1.
REQ-010 seed  in  16  LFSR seed, sampled only while Reset is high.
REQ-011 DrawX, DrawY  in  COORD_W each  current pixel.
REQ-012 platform_on  out  1  registered; pixel lies inside any platform box.
REQ-013 hit_index  out  clog2(N_PLAT)  registered; lowest index whose box contains the pixel, 0 when none.
REQ-014 busy  out  1  high during INIT and UPDATE.
REQ-015 overrun  out  1  sticky flag: a frame_tick arrived while busy was high.

Function
REQ-016 States: RESET_HOLD, INIT, IDLE, UPDATE.
- RESET_HOLD is held while Reset is high.
- RESET_HOLD goes to INIT on the first Clk edge after Reset falls.
REQ-017 INIT writes one platform per cycle, index 0..N_PLAT-1.
- Y_i = i*(SCREEN_H/N_PLAT), using integer division.
- X_i = next mapped LFSR value.
- Goes to IDLE after index N_PLAT-1; takes exactly N_PLAT cycles.
REQ-018 IDLE + frame_tick goes to UPDATE; scroll_amt is captured on that edge and held for the whole pass.
REQ-019 UPDATE processes one index per cycle, 0..N_PLAT-1, then returns to IDLE; takes exactly N_PLAT cycles.
- Let s = Y_i + scroll, computed COORD_W+1 bits wide.
- If s < SCREEN_H: Y_i = s, X_i unchanged.
- Otherwise: Y_i = s - SCREEN_H (wrap to top) and X_i = next mapped LFSR value.
REQ-020 The LFSR is 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advancing every Clk cycle.
- Reset loads seed.
- A zero seed is replaced by 16'hACE1.
REQ-021 X mapping:
- r = lfsr[COORD_W-1:0].
- If r > SCREEN_W-1-2*HALF_W, subtract (SCREEN_W-2*HALF_W) once.
- X = r + HALF_W, so X is always in [HALF_W, SCREEN_W-1-HALF_W].
REQ-022 The parameters shall satisfy SCREEN_W-2*HALF_W >= 2^(COORD_W-1); an elaboration check fails otherwise.
REQ-023 Box test per index: X_i-HALF_W <= DrawX <= X_i+HALF_W and Y_i-HALF_W <= DrawY <= Y_i+HALF_W.
- Compare COORD_W+1 bits wide, signed-safe.
- A Y_i below HALF_W shall not wrap its box to the screen bottom.
REQ-024 Pixel latency: platform_on and hit_index are registered exactly 1 cycle after DrawX/DrawY.
- They are evaluated in every state.
- During INIT/UPDATE they use the mix of old and new entries current in the array.
REQ-025 busy is high exactly in INIT and UPDATE.
REQ-026 frame_tick while busy is ignored and sets overrun; overrun clears only on Reset.
REQ-027 frame_tick in the cycle UPDATE returns to IDLE counts as busy: it is ignored and sets overrun.
REQ-028 scroll_amt = 0 leaves all X/Y unchanged; the LFSR still advances.

Reset
REQ-029 While Reset is high:
- all X_i, Y_i = 0;
- platform_on = 0, hit_index = 0, busy = 0, overrun = 0;
- LFSR = seed (or 16'hACE1 if seed is zero).
REQ-030 Reset asserted during INIT or UPDATE aborts the pass immediately; a full INIT follows deassertion.

Structure
REQ-031 Shared package platform_pkg holds:
- SCREEN_W, SCREEN_H, HALF_W defaults;
- LFSR polynomial constant and the 16'hACE1 fallback;
- typedef plat_t {x, y : COORD_W}.
REQ-032 One sub-module, plat_lfsr: ports Clk, Reset, seed, value[15:0]. Mapping and box tests stay in platform_field.
REQ-033 Platform storage is a register array of plat_t indexed by the INIT/UPDATE counter. No block RAM, because the box test needs all entries every cycle.

Verification (defaults, seed 16'h1234)
REQ-034 Reset release -> busy high 16 cycles, then Y_i = 30*i and every X_i in [4,635]; overrun = 0.
REQ-035 frame_tick with scroll_amt = 0 -> busy 16 cycles; all X/Y unchanged.
REQ-036 Force Y_15 = 475, frame_tick with scroll 10 -> Y_15 = 5, X_15 changes; Y_0 = 10.
REQ-037 Pixel at (X_3, Y_3) -> platform_on = 1, hit_index = 3 one cycle later. At (X_3+5, Y_3) -> platform_on = 0 unless another box covers it.
REQ-038 Second frame_tick 3 cycles after the first -> ignored, overrun = 1, pass still ends at cycle 16.
REQ-039 Reset pulse mid-UPDATE (index 7) -> all outputs 0 during Reset; afterwards a full 16-cycle INIT with Y_i = 30*i.
